// File: rtl/global_b_merger.sv
// Merges the system AXI B responses of one split cluster write into a single B,
// then broadcasts that B to every cluster and waits until each cluster has taken it.
module global_b_merger #(
    parameter int unsigned NrClusters     = 4,
    parameter int unsigned MaxOutstanding = 4,
    parameter int unsigned IdWidth        = 5,
    parameter int unsigned CntWidth       = 8
) (
    input  logic                                   clk_i,
    input  logic                                   rst_ni,
    input  logic                                   split_valid_i,
    input  logic [CntWidth-1:0]                    split_cnt_i,
    output logic                                   split_ready_o,
    input  logic                                   sys_b_valid_i,
    input  logic [1:0]                             sys_b_resp_i,
    input  logic [IdWidth-1:0]                     sys_b_id_i,
    output logic                                   sys_b_ready_o,
    output logic [NrClusters-1:0]                  cl_b_valid_o,
    input  logic [NrClusters-1:0]                  cl_b_ready_i,
    output logic [1:0]                             cl_b_resp_o,
    output logic [IdWidth-1:0]                     cl_b_id_o,
    output logic [$clog2(MaxOutstanding+1)-1:0]    pending_o
);

    localparam int unsigned PtrWidth = (MaxOutstanding > 1) ? $clog2(MaxOutstanding) : 1;
    localparam int unsigned OccWidth = $clog2(MaxOutstanding + 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        BCAST   = 2'd2
    } state_e;

    // EXOKAY is folded as OKAY so that the worst response wins by plain magnitude.
    function automatic logic [1:0] fold_resp(input logic [1:0] acc, input logic [1:0] resp);
        logic [1:0] mapped;
        mapped = (resp == 2'b01) ? 2'b00 : resp;
        return (mapped > acc) ? mapped : acc;
    endfunction

    logic [CntWidth-1:0] fifo_q [MaxOutstanding];
    logic [PtrWidth-1:0] wr_ptr_q, rd_ptr_q;
    logic [OccWidth-1:0] occ_q;
    logic                push, pop;

    state_e              state_q, state_d;
    logic [CntWidth-1:0] remaining_q, remaining_d;
    logic [1:0]          acc_q, acc_d;
    logic [IdWidth-1:0]  id_q, id_d;
    logic                first_q, first_d;
    logic [NrClusters-1:0] acked_q, acked_d;

    assign split_ready_o = (occ_q < OccWidth'(MaxOutstanding));
    assign push          = split_valid_i & split_ready_o;
    assign pending_o     = occ_q;
    assign cl_b_resp_o   = acc_q;
    assign cl_b_id_o     = id_q;

    // Count storage is data only; occupancy and pointers say what is valid.
    always_ff @(posedge clk_i) begin
        if (push) begin
            fifo_q[wr_ptr_q] <= (split_cnt_i == '0) ? CntWidth'(1) : split_cnt_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            occ_q    <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + PtrWidth'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + PtrWidth'(1);
            if (push && !pop)      occ_q <= occ_q + OccWidth'(1);
            else if (!push && pop) occ_q <= occ_q - OccWidth'(1);
        end
    end

    always_comb begin
        state_d       = state_q;
        remaining_d   = remaining_q;
        acc_d         = acc_q;
        id_d          = id_q;
        first_d       = first_q;
        acked_d       = acked_q;
        pop           = 1'b0;
        sys_b_ready_o = 1'b0;
        cl_b_valid_o  = '0;
        unique case (state_q)
            IDLE: begin
                if (occ_q != '0) begin
                    remaining_d = fifo_q[rd_ptr_q];
                    acc_d       = 2'b00;
                    first_d     = 1'b1;
                    state_d     = COLLECT;
                end
            end
            COLLECT: begin
                sys_b_ready_o = 1'b1;
                if (sys_b_valid_i) begin
                    remaining_d = remaining_q - CntWidth'(1);
                    acc_d       = fold_resp(acc_q, sys_b_resp_i);
                    first_d     = 1'b0;
                    if (first_q) id_d = sys_b_id_i;
                    // Stored counts are never zero, so remaining reaches 1 before 0.
                    if (remaining_q == CntWidth'(1)) state_d = BCAST;
                end
            end
            BCAST: begin
                cl_b_valid_o = ~acked_q;
                acked_d      = acked_q | (cl_b_valid_o & cl_b_ready_i);
                if (&acked_d) begin
                    pop     = 1'b1;
                    acked_d = '0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= IDLE;
            remaining_q <= '0;
            acc_q       <= 2'b00;
            id_q        <= '0;
            first_q     <= 1'b0;
            acked_q     <= '0;
        end else begin
            state_q     <= state_d;
            remaining_q <= remaining_d;
            acc_q       <= acc_d;
            id_q        <= id_d;
            first_q     <= first_d;
            acked_q     <= acked_d;
        end
    end

endmodule

// File: tb/tb_global_b_merger.sv
// Directed bench for global_b_merger: grouping, error merge, skewed cluster acks,
// FIFO limits, empty-FIFO stall, cnt=0 handling and mid-group reset.
module tb_global_b_merger;

    localparam int NrClusters = 4;
    localparam int MaxOut     = 4;
    localparam int IdWidth    = 5;
    localparam int CntWidth   = 8;

    logic                  clk_i = 1'b0;
    logic                  rst_ni;
    logic                  split_valid_i;
    logic [CntWidth-1:0]   split_cnt_i;
    logic                  split_ready_o;
    logic                  sys_b_valid_i;
    logic [1:0]            sys_b_resp_i;
    logic [IdWidth-1:0]    sys_b_id_i;
    logic                  sys_b_ready_o;
    logic [NrClusters-1:0] cl_b_valid_o;
    logic [NrClusters-1:0] cl_b_ready_i;
    logic [1:0]            cl_b_resp_o;
    logic [IdWidth-1:0]    cl_b_id_o;
    logic [2:0]            pending_o;

    int total = 0;
    int bad   = 0;

    global_b_merger #(
        .NrClusters(NrClusters), .MaxOutstanding(MaxOut),
        .IdWidth(IdWidth), .CntWidth(CntWidth)
    ) dut (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .split_valid_i(split_valid_i), .split_cnt_i(split_cnt_i), .split_ready_o(split_ready_o),
        .sys_b_valid_i(sys_b_valid_i), .sys_b_resp_i(sys_b_resp_i), .sys_b_id_i(sys_b_id_i),
        .sys_b_ready_o(sys_b_ready_o),
        .cl_b_valid_o(cl_b_valid_o), .cl_b_ready_i(cl_b_ready_i),
        .cl_b_resp_o(cl_b_resp_o), .cl_b_id_o(cl_b_id_o), .pending_o(pending_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_split_ready"}, split_ready_o, 1);
        chk({tag, "_sys_ready"}, sys_b_ready_o, 0);
        chk({tag, "_cl_valid"}, cl_b_valid_o, 0);
        chk({tag, "_resp"}, cl_b_resp_o, 0);
        chk({tag, "_id"}, cl_b_id_o, 0);
        chk({tag, "_pending"}, pending_o, 0);
    endtask

    // All tasks start and end just after a falling edge.
    task automatic push(input logic [CntWidth-1:0] cnt);
        split_valid_i = 1'b1;
        split_cnt_i   = cnt;
        @(negedge clk_i);
        split_valid_i = 1'b0;
    endtask

    task automatic send_b(input logic [1:0] resp, input logic [IdWidth-1:0] id);
        logic ok;
        ok            = 1'b0;
        sys_b_valid_i = 1'b1;
        sys_b_resp_i  = resp;
        sys_b_id_i    = id;
        for (int i = 0; i < 20; i++) begin
            if (sys_b_ready_o) begin
                @(negedge clk_i);
                ok = 1'b1;
                break;
            end
            @(negedge clk_i);
        end
        sys_b_valid_i = 1'b0;
        chk("b_handshake_timeout", ok, 1);
    endtask

    task automatic ack_all();
        cl_b_ready_i = '1;
        @(negedge clk_i);
        cl_b_ready_i = '0;
    endtask

    initial begin
        int dly [NrClusters];
        logic [NrClusters-1:0] exp_v, rdy;
        dly = '{0, 2, 5, 1};

        rst_ni = 1'b0; split_valid_i = 0; split_cnt_i = '0;
        sys_b_valid_i = 0; sys_b_resp_i = '0; sys_b_id_i = '0; cl_b_ready_i = '0;
        @(negedge clk_i); @(negedge clk_i);
        chk_reset_vals("por");
        rst_ni = 1'b1;
        @(negedge clk_i);

        // Single group of three OKAY responses
        push(8'd3);
        chk("g1_pending", pending_o, 1);
        chk("g1_idle_ready", sys_b_ready_o, 0);
        send_b(2'b00, 5'd5);
        send_b(2'b00, 5'd5);
        chk("g1_no_early_valid", cl_b_valid_o, 0);
        send_b(2'b00, 5'd5);
        chk("g1_valid", cl_b_valid_o, 4'hF);
        chk("g1_resp", cl_b_resp_o, 2'b00);
        chk("g1_id", cl_b_id_o, 5);
        chk("g1_bcast_sys_ready", sys_b_ready_o, 0);
        ack_all();
        chk("g1_valid_done", cl_b_valid_o, 0);
        chk("g1_pending_done", pending_o, 0);

        // Error merge
        push(8'd4);
        send_b(2'b00, 5'd1); send_b(2'b10, 5'd2); send_b(2'b01, 5'd3); send_b(2'b00, 5'd4);
        chk("em1_resp", cl_b_resp_o, 2'b10);
        chk("em1_id_first", cl_b_id_o, 1);
        ack_all();
        push(8'd2);
        send_b(2'b11, 5'd6); send_b(2'b10, 5'd7);
        chk("em2_resp", cl_b_resp_o, 2'b11);
        ack_all();

        // Skewed cluster ready
        push(8'd1);
        send_b(2'b00, 5'd8);
        for (int k = 0; k <= 5; k++) begin
            exp_v = '0;
            rdy   = '0;
            for (int c = 0; c < NrClusters; c++) begin
                if (dly[c] >= k) exp_v[c] = 1'b1;
                if (dly[c] == k) rdy[c] = 1'b1;
            end
            chk($sformatf("skew_valid_%0d", k), cl_b_valid_o, exp_v);
            chk($sformatf("skew_pending_%0d", k), pending_o, 1);
            cl_b_ready_i = rdy;
            @(negedge clk_i);
        end
        cl_b_ready_i = '0;
        chk("skew_valid_done", cl_b_valid_o, 0);
        chk("skew_pending_done", pending_o, 0);

        // FIFO full and push/pop interaction
        for (int i = 0; i < 4; i++) push(8'd1);
        chk("full_split_ready", split_ready_o, 0);
        chk("full_pending", pending_o, 4);
        send_b(2'b00, 5'd2);
        chk("full_bcast_pending", pending_o, 4);
        split_valid_i = 1'b1;
        cl_b_ready_i  = '1;
        @(negedge clk_i);
        cl_b_ready_i  = '0;
        chk("full_pop_refused_push", pending_o, 3);
        chk("full_ready_again", split_ready_o, 1);
        @(negedge clk_i);
        split_valid_i = 1'b0;
        chk("full_refill", pending_o, 4);
        send_b(2'b00, 5'd3);
        ack_all();
        chk("full_pop3", pending_o, 3);
        send_b(2'b00, 5'd3);
        split_valid_i = 1'b1;
        cl_b_ready_i  = '1;
        @(negedge clk_i);
        split_valid_i = 1'b0;
        cl_b_ready_i  = '0;
        chk("pushpop_same", pending_o, 3);
        for (int i = 0; i < 3; i++) begin
            send_b(2'b00, 5'd4);
            ack_all();
        end
        chk("drain_pending", pending_o, 0);

        // Sys B with an empty FIFO, then cnt=0
        sys_b_valid_i = 1'b1; sys_b_resp_i = 2'b00; sys_b_id_i = 5'd7;
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("empty_stall_%0d", i), sys_b_ready_o, 0);
            @(negedge clk_i);
        end
        push(8'd0);
        chk("cnt0_idle_ready", sys_b_ready_o, 0);
        chk("cnt0_pending", pending_o, 1);
        @(negedge clk_i);
        chk("cnt0_collect_ready", sys_b_ready_o, 1);
        @(negedge clk_i);
        chk("cnt0_valid", cl_b_valid_o, 4'hF);
        chk("cnt0_one_b_only", sys_b_ready_o, 0);
        chk("cnt0_id", cl_b_id_o, 7);
        sys_b_valid_i = 1'b0;
        ack_all();
        chk("cnt0_pending_done", pending_o, 0);

        // Reset mid-COLLECT
        push(8'd3);
        send_b(2'b10, 5'd9);
        chk("rst_pre_id", cl_b_id_o, 9);
        rst_ni = 1'b0;
        #1;
        chk_reset_vals("midrst");
        @(negedge clk_i);
        rst_ni = 1'b1;
        @(negedge clk_i);
        push(8'd1);
        send_b(2'b00, 5'd3);
        chk("post_rst_valid", cl_b_valid_o, 4'hF);
        chk("post_rst_resp", cl_b_resp_o, 2'b00);
        chk("post_rst_id", cl_b_id_o, 3);
        ack_all();
        chk("post_rst_pending", pending_o, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
